// File: rtl/vend_pkg.sv
// vend_pkg: shared currency widths, coin denominations and dispenser FSM states
package vend_pkg;
   localparam int CURRENCY_WIDTH = 7;
   localparam int NUM_DENOM = 5;
   localparam logic [CURRENCY_WIDTH-1:0] DENOMS [NUM_DENOM] = '{7'd50, 7'd20, 7'd10, 7'd5, 7'd1};
   typedef enum logic [1:0] {IDLE, SELECT, SEND, DONE} state_t;
endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request, hopper handshake and status signals of the change dispenser
interface change_dispenser_if #(
   parameter int CURRENCY_WIDTH = vend_pkg::CURRENCY_WIDTH,
   parameter int NUM_DENOM = vend_pkg::NUM_DENOM
);
   logic change_req;
   logic [CURRENCY_WIDTH-1:0] change_amount;
   logic change_busy;
   logic [CURRENCY_WIDTH-1:0] coin_value;
   logic coin_valid;
   logic coin_ready;
   logic [NUM_DENOM-1:0] denom_empty;
   logic change_done;
   logic change_short;
   logic [CURRENCY_WIDTH-1:0] remaining;
   modport master (
      output change_req, change_amount, coin_ready, denom_empty,
      input change_busy, coin_value, coin_valid, change_done, change_short, remaining
   );
   modport slave (
      input change_req, change_amount, coin_ready, denom_empty,
      output change_busy, coin_value, coin_valid, change_done, change_short, remaining
   );
endinterface

// File: rtl/denom_select.sv
// denom_select: priority pick of the largest stocked denomination not exceeding remaining
module denom_select #(
   parameter int CURRENCY_WIDTH = vend_pkg::CURRENCY_WIDTH,
   parameter int NUM_DENOM = vend_pkg::NUM_DENOM
) (
   input logic [CURRENCY_WIDTH-1:0] remaining,
   input logic [NUM_DENOM-1:0] denom_empty,
   output logic found,
   output logic [$clog2(NUM_DENOM)-1:0] index,
   output logic [CURRENCY_WIDTH-1:0] value
);
   localparam int IW = $clog2(NUM_DENOM);
   // scan smallest to largest so the largest eligible coin is the last one written
   always_comb begin
      found = 1'b0;
      index = '0;
      value = '0;
      for (int i = NUM_DENOM - 1; i >= 0; i--)
         if (!denom_empty[i] && CURRENCY_WIDTH'(vend_pkg::DENOMS[i]) <= remaining) begin
            found = 1'b1;
            index = IW'(i);
            value = CURRENCY_WIDTH'(vend_pkg::DENOMS[i]);
         end
   end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out change_amount coin by coin to a hopper, largest stocked coin first
module change_dispenser #(
   parameter int CURRENCY_WIDTH = vend_pkg::CURRENCY_WIDTH,
   parameter int NUM_DENOM = vend_pkg::NUM_DENOM
) (
   input logic clk,
   input logic rst,
   change_dispenser_if.slave bus
);
   import vend_pkg::*;
   localparam int IW = $clog2(NUM_DENOM);
   state_t state, state_nx;
   logic found, xfer;
   logic [IW-1:0] sel_index;
   logic [CURRENCY_WIDTH-1:0] sel_value;
   assign xfer = bus.coin_valid && bus.coin_ready;
   assign bus.change_busy = state != IDLE;
   denom_select #(.CURRENCY_WIDTH(CURRENCY_WIDTH), .NUM_DENOM(NUM_DENOM)) u_select (
      .remaining(bus.remaining),
      .denom_empty(bus.denom_empty),
      .found(found),
      .index(sel_index),
      .value(sel_value)
   );
   // picked index and value must always name the same coin
   always_comb if (found) assert (CURRENCY_WIDTH'(DENOMS[sel_index]) == sel_value);
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   // next state: a transfer that empties remaining finishes, otherwise pick again
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (bus.change_req) state_nx = bus.change_amount == '0 ? DONE : SELECT;
         SELECT: state_nx = found ? SEND : DONE;
         SEND: if (xfer) state_nx = bus.remaining == bus.coin_value ? DONE : SELECT;
         default: state_nx = IDLE;
      endcase
   end
   // registered coin offer, running balance and the completion pulse
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bus.coin_valid <= 1'b0;
         bus.coin_value <= '0;
         bus.remaining <= '0;
         bus.change_done <= 1'b0;
         bus.change_short <= 1'b0;
      end else begin
         bus.change_done <= state == DONE;
         bus.change_short <= state == DONE && bus.remaining != '0;
         if (state == IDLE && bus.change_req) bus.remaining <= bus.change_amount;
         if (state == SELECT && found) begin
            bus.coin_value <= sel_value;
            bus.coin_valid <= 1'b1;
         end
         if (xfer) begin
            bus.remaining <= bus.remaining - bus.coin_value;
            bus.coin_valid <= 1'b0;
         end
      end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed scenarios with hand-computed coin sequences
module tb_change_dispenser;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   int got[$];
   logic done_seen;
   logic got_short;
   logic [6:0] got_rem;

   change_dispenser_if bus ();
   change_dispenser dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic collect;
      done_seen = 1'b0;
      for (int c = 0; c < 200 && !done_seen; c++) begin
         if (bus.coin_valid && bus.coin_ready) got.push_back(int'(bus.coin_value));
         if (bus.change_done) begin
            done_seen = 1'b1;
            got_short = bus.change_short;
            got_rem = bus.remaining;
         end else @(negedge clk);
      end
   endtask

   task automatic dispense(input logic [6:0] amt, input logic [4:0] empty);
      got.delete();
      bus.denom_empty = empty;
      bus.change_amount = amt;
      bus.coin_ready = 1'b1;
      bus.change_req = 1'b1;
      @(posedge clk);
      #1 bus.change_req = 1'b0;
      @(negedge clk);
      collect();
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.coin_valid !== 1'b0 || bus.coin_value !== 7'd0 || bus.remaining !== 7'd0 || bus.change_done !== 1'b0 || bus.change_short !== 1'b0 || bus.change_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: valid %b value %0d rem %0d done %b short %b busy %b, expected all zero", bus.coin_valid, bus.coin_value, bus.remaining, bus.change_done, bus.change_short, bus.change_busy);
      end
      rst = 1'b0;
   endtask

   task automatic test_full;
      int exp[$] = '{50, 50, 20, 5, 1, 1};
      dispense(7'd127, 5'b00000);
      checks++;
      if (!done_seen || got.size() != exp.size()) begin
         errors++;
         $display("FAIL full_count: done %b coins %0d, expected done 1 coins %0d", done_seen, got.size(), exp.size());
      end else foreach (exp[i]) begin
         checks++;
         if (got[i] != exp[i]) begin
            errors++;
            $display("FAIL full_coin%0d: got %0d expected %0d", i, got[i], exp[i]);
         end
      end
      checks++;
      if (got_short !== 1'b0 || got_rem !== 7'd0) begin
         errors++;
         $display("FAIL full_status: short %b rem %0d, expected short 0 rem 0", got_short, got_rem);
      end
   endtask

   task automatic test_tube_empty;
      int exp[$] = '{10, 10, 10, 5};
      dispense(7'd35, 5'b00010);
      checks++;
      if (!done_seen || got.size() != exp.size()) begin
         errors++;
         $display("FAIL no20_count: done %b coins %0d, expected done 1 coins %0d", done_seen, got.size(), exp.size());
      end else foreach (exp[i]) begin
         checks++;
         if (got[i] != exp[i]) begin
            errors++;
            $display("FAIL no20_coin%0d: got %0d expected %0d", i, got[i], exp[i]);
         end
      end
      checks++;
      if (got_short !== 1'b0 || got_rem !== 7'd0) begin
         errors++;
         $display("FAIL no20_status: short %b rem %0d, expected short 0 rem 0", got_short, got_rem);
      end
   endtask

   task automatic test_short;
      dispense(7'd8, 5'b10000);
      checks++;
      if (!done_seen || got.size() != 1 || got[0] != 5) begin
         errors++;
         $display("FAIL short_coins: done %b coins %0d first %0d, expected done 1 coins 1 first 5", done_seen, got.size(), got.size() > 0 ? got[0] : -1);
      end
      checks++;
      if (got_short !== 1'b1 || got_rem !== 7'd3) begin
         errors++;
         $display("FAIL short_status: short %b rem %0d, expected short 1 rem 3", got_short, got_rem);
      end
   endtask

   task automatic test_zero;
      bus.change_amount = 7'd0;
      bus.change_req = 1'b1;
      @(posedge clk);
      #1 bus.change_req = 1'b0;
      checks++;
      if (bus.change_done !== 1'b0 || bus.coin_valid !== 1'b0 || bus.change_busy !== 1'b1) begin
         errors++;
         $display("FAIL zero_edge1: done %b valid %b busy %b, expected 0 0 1", bus.change_done, bus.coin_valid, bus.change_busy);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.change_done !== 1'b1 || bus.change_short !== 1'b0 || bus.coin_valid !== 1'b0 || bus.remaining !== 7'd0) begin
         errors++;
         $display("FAIL zero_edge2: done %b short %b valid %b rem %0d, expected 1 0 0 0", bus.change_done, bus.change_short, bus.coin_valid, bus.remaining);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.change_done !== 1'b0) begin
         errors++;
         $display("FAIL zero_pulse_width: done %b, expected 0", bus.change_done);
      end
      @(negedge clk);
   endtask

   task automatic test_stall;
      int sum = 0;
      got.delete();
      bus.denom_empty = 5'b00000;
      bus.change_amount = 7'd60;
      bus.coin_ready = 1'b0;
      bus.change_req = 1'b1;
      @(posedge clk);
      #1 bus.change_req = 1'b0;
      checks++;
      if (bus.coin_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_latency_early: valid %b, expected 0", bus.coin_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.coin_valid !== 1'b1 || bus.coin_value !== 7'd50) begin
         errors++;
         $display("FAIL stall_first_coin: valid %b value %0d, expected 1 50", bus.coin_valid, bus.coin_value);
      end
      bus.change_amount = 7'd5;
      bus.change_req = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (bus.coin_valid !== 1'b1 || bus.coin_value !== 7'd50 || bus.remaining !== 7'd60) begin
            errors++;
            $display("FAIL stall_hold%0d: valid %b value %0d rem %0d, expected 1 50 60", c, bus.coin_valid, bus.coin_value, bus.remaining);
         end
      end
      bus.change_req = 1'b0;
      bus.coin_ready = 1'b1;
      collect();
      foreach (got[i]) sum += got[i];
      checks++;
      if (!done_seen || got.size() != 2 || sum != 60 || got[0] != 50) begin
         errors++;
         $display("FAIL stall_total: done %b coins %0d sum %0d, expected done 1 coins 2 sum 60", done_seen, got.size(), sum);
      end
      checks++;
      if (got_short !== 1'b0 || got_rem !== 7'd0) begin
         errors++;
         $display("FAIL stall_status: short %b rem %0d, expected short 0 rem 0", got_short, got_rem);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (bus.change_busy !== 1'b0 || bus.remaining !== 7'd0) begin
         errors++;
         $display("FAIL stall_no_queue: busy %b rem %0d, expected busy 0 rem 0", bus.change_busy, bus.remaining);
      end
   endtask

   task automatic test_reset_mid_send;
      bus.denom_empty = 5'b00000;
      bus.change_amount = 7'd70;
      bus.coin_ready = 1'b0;
      bus.change_req = 1'b1;
      @(posedge clk);
      #1 bus.change_req = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus.coin_valid !== 1'b1 || bus.coin_value !== 7'd50 || bus.change_busy !== 1'b1) begin
         errors++;
         $display("FAIL rstsend_offer: valid %b value %0d busy %b, expected 1 50 1", bus.coin_valid, bus.coin_value, bus.change_busy);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.coin_valid !== 1'b0 || bus.coin_value !== 7'd0 || bus.remaining !== 7'd0 || bus.change_done !== 1'b0 || bus.change_short !== 1'b0 || bus.change_busy !== 1'b0) begin
         errors++;
         $display("FAIL rstsend_async: valid %b value %0d rem %0d done %b short %b busy %b, expected all zero", bus.coin_valid, bus.coin_value, bus.remaining, bus.change_done, bus.change_short, bus.change_busy);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.coin_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (bus.change_done !== 1'b0 || bus.change_busy !== 1'b0) begin
            errors++;
            $display("FAIL rstsend_no_done: done %b busy %b, expected 0 0", bus.change_done, bus.change_busy);
         end
      end
      dispense(7'd20, 5'b00000);
      checks++;
      if (!done_seen || got.size() != 1 || got[0] != 20) begin
         errors++;
         $display("FAIL rstsend_after: done %b coins %0d first %0d, expected done 1 coins 1 first 20", done_seen, got.size(), got.size() > 0 ? got[0] : -1);
      end
      checks++;
      if (got_short !== 1'b0 || got_rem !== 7'd0) begin
         errors++;
         $display("FAIL rstsend_after_status: short %b rem %0d, expected short 0 rem 0", got_short, got_rem);
      end
   endtask

   initial begin
      bus.change_req = 1'b0;
      bus.change_amount = 7'd0;
      bus.coin_ready = 1'b0;
      bus.denom_empty = 5'b00000;
      test_reset();
      @(negedge clk);
      test_full();
      test_tube_empty();
      test_short();
      test_zero();
      test_stall();
      test_reset_mid_send();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
